// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Shared constants and types for the CGE power adder tree.
//   - BITS_DEF / CGES_DEF / MAX_DEF : default weight width, CGE count and
//     accumulator width.
//   - state_t : run-control state encoding (IDLE=0, RUN=1, DONE=2).
//   - csa_* functions : elaboration-time helpers that size each level of
//     the 3:2 compressor tree.
package adder_tree_pkg;

  localparam int BITS_DEF = 32;
  localparam int CGES_DEF = 13;
  localparam int MAX_DEF  = $clog2(CGES_DEF) + BITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand count after one row of 3:2 compressors: every full group of
  // three becomes two, leftovers pass straight through.
  function automatic int csa_next(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Number of compressor rows needed to get down to two operands.
  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next(c);
      l++;
    end
    return l;
  endfunction

  // Operand count entering compressor row lvl.
  function automatic int csa_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) begin
      c = csa_next(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/ks_adder.sv
// ks_adder
//   Kogge-Stone parallel-prefix adder, carry-in 0, carry-out dropped so the
//   result wraps modulo 2^WIDTH.
//   Ports:
//     a, b : WIDTH-bit addends
//     sum  : (a + b) mod 2^WIDTH
module ks_adder #(
  parameter int WIDTH = 36
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int STAGES = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  // Prefix stages with doubling span. Low bits with no partner at the
  // current span keep their group generate; their group propagate is
  // forced through by the low mask so later stages see it unchanged.
  // After the last stage gen[i] is the carry out of bit i, so the carry
  // into bit i is gen shifted up by one.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    for (int s = 0; s < STAGES; s++) begin
      gen  = gen | (prop & (gen << (1 << s)));
      prop = prop & ((prop << (1 << s)) | ~({WIDTH{1'b1}} << (1 << s)));
    end
    sum = (a ^ b) ^ (gen << 1);
  end

endmodule

// File: rtl/adder_tree_top.sv
// adder_tree_top
//   Sums the power weights of the currently enabled clock-gated elements
//   with a carry-save tree, registers the result in redundant form (vs/vc)
//   and, during a run, accumulates vs+vc into a total every clock.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     start        : level request to begin a run (clears the total)
//     fin          : level request to end the run and freeze the total
//     cge_en       : per-CGE enable for this cycle
//     cge_weight   : CGE i weight in bits [i*BITS +: BITS]
//     vs, vc       : registered sum / carry vectors of the tree
//     result       : accumulated total
//     busy         : high while a run is in progress
module adder_tree_top
  import adder_tree_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int CGES = CGES_DEF,
  parameter int MAX  = $clog2(CGES) + BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 fin,
  input  logic [CGES-1:0]      cge_en,
  input  logic [CGES*BITS-1:0] cge_weight,
  output logic [MAX-1:0]       vs,
  output logic [MAX-1:0]       vc,
  output logic [MAX-1:0]       result,
  output logic                 busy
);

  localparam int LEVELS = csa_levels(CGES);

  logic [MAX-1:0] leaf [CGES];
  logic [MAX-1:0] vs_next;
  logic [MAX-1:0] vc_next;

  // Disabled CGEs contribute zero; weights are zero-extended so the tree
  // has headroom for the full sum.
  for (genvar i = 0; i < CGES; i++) begin : g_leaf
    assign leaf[i] = cge_en[i] ? MAX'(cge_weight[i*BITS +: BITS]) : '0;
  end

  // Each row takes the previous row's operands, compresses full groups of
  // three into a sum/carry pair and passes leftovers through. Rows are
  // separate generate scopes so the tree is a plain feed-forward network.
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int N_IN  = csa_count(CGES, l);
    localparam int N_CSA = N_IN / 3;
    localparam int N_OUT = csa_count(CGES, l + 1);

    logic [MAX-1:0] cur [N_IN];
    logic [MAX-1:0] nxt [N_OUT];

    if (l == 0) begin : g_src_leaf
      assign cur = leaf;
    end else begin : g_src_prev
      assign cur = g_level[l-1].nxt;
    end

    for (genvar j = 0; j < N_CSA; j++) begin : g_csa
      assign nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
      assign nxt[2*j+1] = ((cur[3*j]   & cur[3*j+1]) |
                           (cur[3*j]   & cur[3*j+2]) |
                           (cur[3*j+1] & cur[3*j+2])) << 1;
    end

    for (genvar k = 0; k < N_IN - 3 * N_CSA; k++) begin : g_pass
      assign nxt[2*N_CSA+k] = cur[3*N_CSA+k];
    end
  end

  if (LEVELS > 0) begin : g_root_tree
    assign vs_next = g_level[LEVELS-1].nxt[0];
    assign vc_next = g_level[LEVELS-1].nxt[1];
  end else if (CGES == 2) begin : g_root_two
    assign vs_next = leaf[0];
    assign vc_next = leaf[1];
  end else begin : g_root_one
    assign vs_next = leaf[0];
    assign vc_next = '0;
  end

  // Tree outputs are captured every cycle regardless of run state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs <= '0;
      vc <= '0;
    end else begin
      vs <= vs_next;
      vc <= vc_next;
    end
  end

  // Accumulator update: fold acc, vs and vc down to two vectors with one
  // more compressor row, then resolve with the prefix adder.
  logic [MAX-1:0] acc;
  logic [MAX-1:0] acc_next;
  logic [MAX-1:0] acc_s;
  logic [MAX-1:0] acc_c;
  logic [MAX-1:0] acc_sum;

  assign acc_s = acc ^ vs ^ vc;
  assign acc_c = ((acc & vs) | (acc & vc) | (vs & vc)) << 1;

  ks_adder #(
    .WIDTH(MAX)
  ) u_ks_adder (
    .a  (acc_s),
    .b  (acc_c),
    .sum(acc_sum)
  );

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  // fin is only looked at in RUN, so start+fin together from IDLE gives one
  // accumulating edge before DONE, and fin in RUN wins over start.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          acc_next   = '0;
        end
      end
      RUN: begin
        acc_next = acc_sum;
        if (fin) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
      end
    endcase
  end

  assign result = acc;
  assign busy   = (state == RUN);

endmodule

// File: tb/tb_adder_tree_top.sv
// tb_adder_tree_top
//   Self-checking bench for adder_tree_top. Expected tree sums and run
//   totals come from a behavioural model, are queued when stimulus is
//   applied and compared when the DUT produces them.
module tb_adder_tree_top;

  localparam int BITS = 32;
  localparam int CGES = 13;
  localparam int MAX  = 36;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic                 fin;
  logic [CGES-1:0]      cge_en;
  logic [CGES*BITS-1:0] cge_weight;
  logic [MAX-1:0]       vs;
  logic [MAX-1:0]       vc;
  logic [MAX-1:0]       result;
  logic                 busy;

  int n_checks;
  int n_passed;

  logic [MAX-1:0] sb_q [$];

  adder_tree_top #(
    .BITS(BITS),
    .CGES(CGES),
    .MAX (MAX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .fin       (fin),
    .cge_en    (cge_en),
    .cge_weight(cge_weight),
    .vs        (vs),
    .vc        (vc),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] tree_model();
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < CGES; i++) begin
      if (cge_en[i]) s = s + 64'(cge_weight[i*BITS +: BITS]);
    end
    return s;
  endfunction

  task automatic set_all_weights(input logic [BITS-1:0] w);
    for (int i = 0; i < CGES; i++) cge_weight[i*BITS +: BITS] = w;
  endtask

  task automatic set_random_weights();
    for (int i = 0; i < CGES; i++) cge_weight[i*BITS +: BITS] = $urandom;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    fin     = 1'b0;
    set_all_weights(32'h1234_5678);
    cge_en  = '1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (vs !== '0) $display("[TB] FAIL reset_vs: got %0h expected 0", vs);
    else n_passed++;
    n_checks++;
    if (vc !== '0) $display("[TB] FAIL reset_vc: got %0h expected 0", vc);
    else n_passed++;
    n_checks++;
    if (result !== '0) $display("[TB] FAIL reset_result: got %0h expected 0", result);
    else n_passed++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
    else n_passed++;
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_tree();
    logic [MAX-1:0] exp;
    logic [MAX-1:0] got;
    start = 1'b0;
    fin   = 1'b0;
    for (int i = 0; i < CGES; i++) cge_weight[i*BITS +: BITS] = BITS'(i + 1);
    cge_en = 13'h07FF;
    sb_q.push_back(MAX'(tree_model()));
    tick();
    exp = sb_q.pop_front();
    got = vs + vc;
    n_checks++;
    if (got !== exp) $display("[TB] FAIL tree_07ff: got %0d expected %0d", got, exp);
    else n_passed++;
    n_checks++;
    if (got !== 36'd66) $display("[TB] FAIL tree_66: got %0d expected 66", got);
    else n_passed++;
    for (int p = 0; p < 6; p++) begin
      if (p == 0) begin
        set_all_weights('1);
        cge_en = '1;
      end else if (p == 1) begin
        cge_en = '0;
      end else begin
        set_random_weights();
        cge_en = CGES'($urandom);
      end
      sb_q.push_back(MAX'(tree_model()));
      tick();
      exp = sb_q.pop_front();
      got = vs + vc;
      n_checks++;
      if (got !== exp) $display("[TB] FAIL tree_pattern%0d: got %0h expected %0h", p, got, exp);
      else n_passed++;
    end
  endtask

  task automatic run_accum(input int n, input bit rand_en, input string name);
    logic [63:0]    model;
    logic [MAX-1:0] exp;
    model = 64'd0;
    start = 1'b1;
    fin   = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (rand_en) cge_en = CGES'($urandom);
      model = model + tree_model();
      tick();
      n_checks++;
      if (busy !== 1'b1) $display("[TB] FAIL %s_busy_cycle%0d: got %0b expected 1", name, c, busy);
      else n_passed++;
    end
    fin = 1'b1;
    sb_q.push_back(MAX'(model));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (result !== exp) $display("[TB] FAIL %s_result: got %0h expected %0h", name, result, exp);
    else n_passed++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL %s_busy_done: got %0b expected 0", name, busy);
    else n_passed++;
    repeat (2) tick();
    n_checks++;
    if (result !== exp) $display("[TB] FAIL %s_hold_done: got %0h expected %0h", name, result, exp);
    else n_passed++;
    start = 1'b0;
    fin   = 1'b0;
    tick();
    n_checks++;
    if (result !== exp || busy !== 1'b0)
      $display("[TB] FAIL %s_hold_idle: got result %0h busy %0b expected %0h busy 0", name, result, busy, exp);
    else n_passed++;
  endtask

  task automatic test_basic_run();
    set_all_weights(32'd1);
    cge_en = '1;
    run_accum(4, 1'b0, "basic");
    n_checks++;
    if (result !== 36'd52) $display("[TB] FAIL basic_52: got %0d expected 52", result);
    else n_passed++;
  endtask

  task automatic test_wrap();
    set_all_weights('1);
    cge_en = '1;
    run_accum(40, 1'b0, "wrap");
  endtask

  task automatic test_random_run();
    set_random_weights();
    run_accum(10, 1'b1, "random");
  endtask

  task automatic test_zero_en();
    set_random_weights();
    cge_en = '0;
    run_accum(5, 1'b0, "zero_en");
    n_checks++;
    if (vs !== '0 || vc !== '0) $display("[TB] FAIL zero_en_vs_vc: got vs %0h vc %0h expected 0 0", vs, vc);
    else n_passed++;
    n_checks++;
    if (result !== '0) $display("[TB] FAIL zero_en_result: got %0h expected 0", result);
    else n_passed++;
  endtask

  task automatic test_start_fin();
    logic [MAX-1:0] exp;
    set_random_weights();
    cge_en = CGES'($urandom);
    start  = 1'b1;
    fin    = 1'b1;
    sb_q.push_back(MAX'(tree_model()));
    tick();
    n_checks++;
    if (busy !== 1'b1) $display("[TB] FAIL start_fin_e0_busy: got %0b expected 1", busy);
    else n_passed++;
    cge_en = ~cge_en;
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL start_fin_e1_busy: got %0b expected 0", busy);
    else n_passed++;
    n_checks++;
    if (result !== exp) $display("[TB] FAIL start_fin_result: got %0h expected %0h", result, exp);
    else n_passed++;
    start = 1'b0;
    fin   = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [63:0] model;
    set_random_weights();
    cge_en = '1;
    model  = 64'd0;
    start  = 1'b1;
    fin    = 1'b0;
    tick();
    model = model + tree_model();
    tick();
    model = model + tree_model();
    tick();
    n_checks++;
    if (result !== MAX'(model) || busy !== 1'b1)
      $display("[TB] FAIL midrun_before_reset: got %0h busy %0b expected %0h busy 1", result, busy, MAX'(model));
    else n_passed++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (vs !== '0 || vc !== '0) $display("[TB] FAIL midrun_reset_vs_vc: got vs %0h vc %0h expected 0 0", vs, vc);
    else n_passed++;
    n_checks++;
    if (result !== '0) $display("[TB] FAIL midrun_reset_result: got %0h expected 0", result);
    else n_passed++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL midrun_reset_busy: got %0b expected 0", busy);
    else n_passed++;
    #2;
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (result !== '0 || busy !== 1'b0)
      $display("[TB] FAIL midrun_after_reset: got %0h busy %0b expected 0 busy 0", result, busy);
    else n_passed++;
  endtask

  initial begin
    n_checks   = 0;
    n_passed   = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    fin        = 1'b0;
    cge_en     = '0;
    cge_weight = '0;
    test_reset();
    test_tree();
    test_basic_run();
    test_start_fin();
    test_wrap();
    test_random_run();
    test_zero_en();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_tree_top.md
ADDER_TREE_TOP -- requirements
Module: adder_tree_top

Interface
REQ-001 SHALL have parameter BITS, default 32, width of each CGE power weight.
REQ-002 SHALL have parameter CGES, default 13, number of clock-gated elements summed.
REQ-003 SHALL have parameter MAX, default $clog2(CGES)+BITS (36), width of vs, vc and result.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1, reset_n input 1.
REQ-005 SHALL have port start, input, 1 bit, level request to begin an accumulation run.
REQ-006 SHALL have port fin, input, 1 bit, level request to end the run and freeze result.
REQ-007 SHALL have port cge_en, input, CGES bits, per-cycle enable of each CGE.
REQ-008 SHALL have port cge_weight, input, CGES*BITS bits, CGE i weight in bits [i*BITS +: BITS].
REQ-009 SHALL have port vs, output, MAX bits, registered carry-save sum vector.
REQ-010 SHALL have port vc, output, MAX bits, registered carry-save carry vector.
REQ-011 SHALL have port result, output, MAX bits, accumulated power total.
REQ-012 SHALL have port busy, output, 1 bit, high while state is RUN.

Function
REQ-013 SHALL reduce the enabled weights with a carry-save (3:2 compressor) tree, zero-extended to MAX bits.
REQ-014 SHALL register the tree outputs every clock edge, unconditionally, so that (vs+vc) mod 2^MAX equals the sum of cge_weight[i] over all i with cge_en[i]=1, as sampled at the previous edge.
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE with start=1, clear the accumulator and go to RUN; otherwise it SHALL stay in IDLE and hold the accumulator.
REQ-017 SHALL, on every edge in RUN, update acc <= (acc + vs + vc) mod 2^MAX, including the edge where fin=1.
REQ-018 SHALL compute acc+vs+vc with one further 3:2 compressor row followed by a Kogge-Stone parallel-prefix adder of MAX bits; the final carry-out is discarded (wrap-around).
REQ-019 SHALL, in RUN with fin=1, go to DONE after that edge's accumulation.
REQ-020 SHALL, in RUN with fin=0, stay in RUN regardless of start.
REQ-021 SHALL, in DONE, hold the accumulator, leave DONE for IDLE when start=0, and ignore fin.
REQ-022 SHALL give fin priority over start when both are high in RUN.
REQ-023 SHALL, when start and fin are both high in IDLE, go to RUN only; fin is evaluated from the following edge.
REQ-024 SHALL drive result directly from the accumulator register in every state.
REQ-025 SHALL, for a run with edges E0 (IDLE->RUN) through En (fin seen), set result = sum of tree sums of the inputs sampled at E0..E(n-1).

Reset
REQ-026 SHALL, on asserted reset_n (low), asynchronously clear vs, vc, result/accumulator and busy to 0 and set the state to IDLE.
REQ-027 SHALL, on reset asserted mid-run, abort the run immediately with no partial result retained.

Structure
REQ-028 SHALL take the default BITS/CGES/MAX constants and the state encoding (IDLE=0, RUN=1, DONE=2) from a shared package, adder_tree_pkg.
REQ-029 SHALL place the Kogge-Stone adder in one sub-module, ks_adder, parameterised by width.
REQ-030 SHALL keep the CSA tree as generate logic inside adder_tree_top.

Verification
REQ-031 SHALL cover: all 13 weights=1, cge_en=all ones, start high at E0, fin high at E4 -> result=52 after E4, busy low, result held while start held.
REQ-032 SHALL cover: weights i+1, cge_en=13'h07FF (CGEs 0..10) constant -> vs+vc=66 one edge after inputs applied.
REQ-033 SHALL cover: all weights=32'hFFFFFFFF, all enabled, long run -> result equals (k*13*(2^32-1)) mod 2^36 after k accumulated cycles (wrap-around check).
REQ-034 SHALL cover: reset_n pulsed low mid-RUN without a clock edge -> vs, vc, result=0 and busy=0 immediately.
REQ-035 SHALL cover: start and fin held high together from IDLE -> exactly one accumulating edge (inputs of E0), then DONE.
REQ-036 SHALL cover: cge_en=0 throughout a run -> result=0 and vs=vc=0.
